// File: rtl/memctrl_pkg.sv
// Shared types and constants for the banked memory controller.
package memctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_WAIT,
    ST_WR_DONE
  } state_e;

  localparam int WAIT_W = 4;

  function automatic int bank_w(input int banks);
    return (banks < 2) ? 1 : $clog2(banks);
  endfunction

endpackage

// File: rtl/mem_ctrl_banked_if.sv
// Control strobes and status of the banked memory controller; the tri-state
// data bus stays a plain inout net on the controller.
interface mem_ctrl_banked_if #(
  parameter int ADDR_W = 16,
  parameter int BANK_W = 2
);
  logic              set_mar;
  logic              read_m;
  logic              write_m;
  logic              read_r;
  logic              write_r;
  logic              programming_mode;
  logic              set_mar_btn;
  logic              set_ram_btn;
  logic [ADDR_W-1:0] address;
  logic [BANK_W-1:0] current_ram;
  logic              ready;
  logic              busy;

  modport master (
    output set_mar, read_m, write_m, read_r, write_r,
    output programming_mode, set_mar_btn, set_ram_btn,
    input  address, current_ram, ready, busy
  );

  modport slave (
    input  set_mar, read_m, write_m, read_r, write_r,
    input  programming_mode, set_mar_btn, set_ram_btn,
    output address, current_ram, ready, busy
  );
endinterface

// File: rtl/mc_btn_sync.sv
// Front-panel button conditioner: 2-flop synchroniser followed by a
// one-cycle rising-edge pulse.
module mc_btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;
endmodule

// File: rtl/mem_ctrl_banked.sv
// Banked, wait-state-aware RAM controller on a shared tri-state data bus.
// Define MEMCTRL_PROG_AUTOINC_EN to bump MAR after each front-panel RAM write.
module mem_ctrl_banked
  import memctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int BANKS       = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] data_bus,
  mem_ctrl_banked_if.slave  bus_if
);
  localparam int BANK_W   = bank_w(BANKS);
  localparam int DEPTH_AW = $clog2(DEPTH);
  localparam int IDX_W    = BANK_W + DEPTH_AW;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_L  = WAIT_W'(WAIT_STATES);
`ifdef MEMCTRL_PROG_AUTOINC_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`endif

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [BANKS*DEPTH];

  logic                ram_we;
  logic [IDX_W-1:0]    ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                rd_en;
  logic [IDX_W-1:0]    cur_idx;
  logic                in_range;
  logic [1:0]          btn_raw;
  logic [1:0]          btn_pulse;
  logic                mar_pulse;
  logic                ram_pulse;
  logic                drive_en;
  logic [DATA_W-1:0]   drive_val;

  assign btn_raw   = {bus_if.set_ram_btn, bus_if.set_mar_btn};
  assign mar_pulse = btn_pulse[0];
  assign ram_pulse = btn_pulse[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    mc_btn_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_raw[gi]),
      .pulse_o (btn_pulse[gi])
    );
  end

  assign cur_idx  = {bank_q, addr_q[DEPTH_AW-1:0]};
  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    idx_d     = idx_q;
    oor_d     = oor_q;
    wdata_d   = wdata_q;
    ram_we    = 1'b0;
    ram_waddr = cur_idx;
    ram_wdata = data_bus;
    rd_en     = 1'b0;

    if (bus_if.programming_mode) begin
      // Front panel owns the controller; any bus transaction in flight is dropped.
      state_d = ST_IDLE;
      if (ram_pulse && in_range) begin
        ram_we = 1'b1;
      end
`ifdef MEMCTRL_PROG_AUTOINC_EN
      if (ram_pulse) begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      end
`endif
      if (mar_pulse) begin
        addr_d = data_bus[ADDR_W-1:0];
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.set_mar) begin
            addr_d = data_bus[ADDR_W-1:0];
          end else if (bus_if.write_r) begin
            bank_d = data_bus[BANK_W-1:0];
          end else if (bus_if.write_m) begin
            idx_d   = cur_idx;
            oor_d   = ~in_range;
            wdata_d = data_bus;
            cnt_d   = WAIT_L;
            state_d = ST_WR_WAIT;
          end else if (bus_if.read_m) begin
            idx_d   = cur_idx;
            oor_d   = ~in_range;
            cnt_d   = WAIT_L;
            state_d = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!bus_if.read_m) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            rd_en   = 1'b1;
            state_d = ST_RD_DONE;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
        ST_RD_DONE: begin
          if (!bus_if.read_m) begin
            state_d = ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (cnt_q == '0) begin
            ram_we    = ~oor_q;
            ram_waddr = idx_q;
            ram_wdata = wdata_q;
            state_d   = ST_WR_DONE;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
        ST_WR_DONE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage is not reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[idx_q];
    end
  end

  assign drive_en  = ~bus_if.programming_mode &
                     (bus_if.read_r | ((state_q == ST_RD_DONE) & bus_if.read_m));
  assign drive_val = bus_if.read_r ? DATA_W'(bank_q) : (oor_q ? '0 : rd_data_q);
  assign data_bus  = drive_en ? drive_val : 'z;

  assign bus_if.address     = addr_q;
  assign bus_if.current_ram = bank_q;
  assign bus_if.busy        = (state_q != ST_IDLE);
  assign bus_if.ready       = ~bus_if.programming_mode &
                              (((state_q == ST_RD_DONE) & bus_if.read_m) |
                               (state_q == ST_WR_DONE));
endmodule

// File: tb/tb_mem_ctrl_banked.sv
// Directed self-checking bench for mem_ctrl_banked (WAIT_STATES=1, DEPTH=256, 4 banks).
module tb_mem_ctrl_banked;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_val = '0;
  wire  [15:0] data_bus;
  int          checks = 0;
  int          errors = 0;

  assign data_bus = tb_drv ? tb_val : 'z;

  mem_ctrl_banked_if #(.ADDR_W(16), .BANK_W(2)) bif ();

  mem_ctrl_banked #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .BANKS(4), .WAIT_STATES(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_bus (data_bus),
    .bus_if   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    tb_drv = 1'b1; tb_val = v; bif.set_mar = 1'b1;
    tick;
    bif.set_mar = 1'b0; tb_drv = 1'b0;
    chk("mar_load", 32'(bif.address), 32'(v));
    $display("set_mar   addr=0x%04h", bif.address);
  endtask

  task automatic load_bank(input logic [1:0] b);
    tb_drv = 1'b1; tb_val = 16'(b); bif.write_r = 1'b1;
    tick;
    bif.write_r = 1'b0; tb_drv = 1'b0;
    chk("bank_load", 32'(bif.current_ram), 32'(b));
    $display("write_r   bank=%0d", bif.current_ram);
  endtask

  task automatic mem_write(input logic [15:0] v);
    tb_drv = 1'b1; tb_val = v; bif.write_m = 1'b1;
    tick;
    bif.write_m = 1'b0; tb_drv = 1'b0;
    chk("wr_busy", 32'(bif.busy), 32'd1);
    tick;
    chk("wr_ready_early", 32'(bif.ready), 32'd0);
    tick;
    chk("wr_ready", 32'(bif.ready), 32'd1);
    tick;
    chk("wr_ready_once", 32'(bif.ready), 32'd0);
    chk("wr_idle", 32'(bif.busy), 32'd0);
    $display("write_m   addr=0x%04h bank=%0d data=0x%04h", bif.address, bif.current_ram, v);
  endtask

  task automatic mem_read(input logic [15:0] exp);
    bif.read_m = 1'b1;
    tick;
    chk("rd_ready_k", 32'(bif.ready), 32'd0);
    tick;
    chk("rd_ready_k1", 32'(bif.ready), 32'd0);
    tick;
    chk("rd_ready", 32'(bif.ready), 32'd1);
    chk("rd_data", 32'(data_bus), 32'(exp));
    $display("read_m    addr=0x%04h bank=%0d data=0x%04h", bif.address, bif.current_ram, data_bus);
    bif.read_m = 1'b0;
    #1;
    chk("rd_ready_drop", 32'(bif.ready), 32'd0);
    tick;
    chk("rd_idle", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    bif.set_mar = 1'b0; bif.read_m = 1'b0; bif.write_m = 1'b0;
    bif.read_r = 1'b0; bif.write_r = 1'b0; bif.programming_mode = 1'b0;
    bif.set_mar_btn = 1'b0; bif.set_ram_btn = 1'b0;

    // Reset values
    #1 reset = 1'b1;
    #2;
    chk("rst_address", 32'(bif.address), 32'd0);
    chk("rst_bank", 32'(bif.current_ram), 32'd0);
    chk("rst_ready", 32'(bif.ready), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    $display("reset     addr=0x%04h busy=%0d ready=%0d", bif.address, bif.busy, bif.ready);
    @(negedge clk) reset = 1'b0;
    tick;

    // Basic write / read-back in bank 0
    load_mar(16'd5);
    mem_write(16'hBEEF);
    mem_read(16'hBEEF);

    // Bank separation
    load_bank(2'd1);
    mem_write(16'h1234);
    load_bank(2'd0);
    mem_read(16'hBEEF);
    load_bank(2'd1);
    mem_read(16'h1234);
    bif.read_r = 1'b1;
    #1;
    chk("read_r", 32'(data_bus), 32'h0001);
    $display("read_r    bus=0x%04h", data_bus);
    bif.programming_mode = 1'b1; tb_drv = 1'b1; tb_val = 16'h0000;
    #1;
    chk("read_r_pm_blocked", 32'(data_bus), 32'h0000);
    bif.read_r = 1'b0; bif.programming_mode = 1'b0; tb_drv = 1'b0;
    tick;
    load_bank(2'd0);

    // Out-of-range access: dropped write, zero read, aliasing word untouched
    load_mar(16'd44);
    mem_write(16'h5555);
    load_mar(16'd300);
    mem_write(16'hAAAA);
    mem_read(16'h0000);
    load_mar(16'd44);
    mem_read(16'h5555);

    // Read aborted in RD_WAIT
    load_mar(16'd5);
    bif.read_m = 1'b1;
    tick;
    chk("abort_busy", 32'(bif.busy), 32'd1);
    bif.read_m = 1'b0;
    tick;
    chk("abort_idle", 32'(bif.busy), 32'd0);
    chk("abort_ready", 32'(bif.ready), 32'd0);
    tb_drv = 1'b1; tb_val = 16'h0000;
    #1;
    chk("abort_bus_free", 32'(data_bus), 32'h0000);
    tb_drv = 1'b0;
    $display("abort     busy=%0d ready=%0d", bif.busy, bif.ready);
    tick;

    // Programming mode asserted mid-write cancels it
    load_mar(16'd6);
    mem_write(16'h0606);
    tb_drv = 1'b1; tb_val = 16'h7777; bif.write_m = 1'b1;
    tick;
    bif.write_m = 1'b0; tb_drv = 1'b0;
    bif.programming_mode = 1'b1;
    #1;
    chk("pm_ready", 32'(bif.ready), 32'd0);
    tick;
    chk("pm_idle", 32'(bif.busy), 32'd0);
    $display("pm_cancel busy=%0d", bif.busy);
    bif.programming_mode = 1'b0;
    tick;
    mem_read(16'h0606);

    // Front-panel programming
    load_mar(16'd25);
    mem_write(16'h0000);
    load_mar(16'd3);
    bif.programming_mode = 1'b1;
    tick;
    tb_drv = 1'b1; tb_val = 16'd25;
    #2 bif.set_mar_btn = 1'b1;
    tick;
    tick;
    chk("btn_mar_early", 32'(bif.address), 32'd3);
    tick;
    chk("btn_mar", 32'(bif.address), 32'd25);
    $display("mar_btn   addr=%0d", bif.address);
    bif.set_mar_btn = 1'b0; tb_val = 16'd225;
    tick;
    tick;
    #2 bif.set_ram_btn = 1'b1;
    tick;
    tick;
    chk("btn_ram_early", 32'(dut.mem_q[25]), 32'd0);
    tick;
    chk("btn_ram", 32'(dut.mem_q[25]), 32'd225);
`ifdef MEMCTRL_PROG_AUTOINC_EN
    chk("btn_autoinc", 32'(bif.address), 32'd26);
`else
    chk("btn_hold_addr", 32'(bif.address), 32'd25);
`endif
    $display("ram_btn   mem[0][25]=%0d addr=%0d", dut.mem_q[25], bif.address);
    tb_val = 16'd99;
    tick; tick; tick;
    chk("btn_held_once", 32'(dut.mem_q[25]), 32'd225);
`ifdef MEMCTRL_PROG_AUTOINC_EN
    chk("btn_held_addr", 32'(bif.address), 32'd26);
`else
    chk("btn_held_addr", 32'(bif.address), 32'd25);
`endif
    bif.set_ram_btn = 1'b0; tb_drv = 1'b0; bif.programming_mode = 1'b0;
    tick; tick; tick;

    // Asynchronous reset during WR_WAIT
    load_mar(16'd7);
    mem_write(16'h1111);
    tb_drv = 1'b1; tb_val = 16'h2222; bif.write_m = 1'b1;
    tick;
    bif.write_m = 1'b0; tb_drv = 1'b0;
    chk("rstw_busy", 32'(bif.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_busy0", 32'(bif.busy), 32'd0);
    chk("rstw_ready0", 32'(bif.ready), 32'd0);
    chk("rstw_addr0", 32'(bif.address), 32'd0);
    $display("async_rst busy=%0d ready=%0d addr=%0d", bif.busy, bif.ready, bif.address);
    @(negedge clk) reset = 1'b0;
    tick;
    load_mar(16'd7);
    mem_read(16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
